// File: rtl/bless_route_stage.sv
// -----------------------------------------------------------------------------
// bless_route_stage
//
// Pipeline stage that sits directly in front of the 1-to-5 output demux of a
// bufferless (BLESS) router. It registers one flit per cycle, computes the
// demux select with dimension-ordered (X then Y) routing, bumps the flit age
// with saturation, and tracks ejection-port credits. When a flit wants to
// eject locally but no credit is left, it is deflected onto a mesh direction
// chosen round-robin, because a bufferless router can never hold a flit back.
//
// Ports:
//   clk            in   1        clock, all state on rising edge
//   reset          in   1        synchronous, active-high reset
//   cur_x          in   COORD_W  this router's X coordinate (static)
//   cur_y          in   COORD_W  this router's Y coordinate (static)
//   flit_in        in   WIDTH    incoming flit
//   valid_in       in   1        flit_in valid this cycle
//   hold           in   1        stall: stage register and pointer frozen
//   ej_credit_ret  in   1        one ejection credit returned this cycle
//   flit_out       out  WIDTH    registered flit with updated age
//   valid_out      out  1        flit_out valid
//   sel_out        out  3        demux select (000 N, 001 E, 010 S, 011 W, 100 L)
//   deflect_out    out  1        registered flit was deflected away from Local
//   credits_out    out  3        current ejection credit count
//
// Flit layout (MSB first): dst_x | dst_y | age | payload.
// -----------------------------------------------------------------------------
module bless_route_stage #(
  parameter int WIDTH      = 64,
  parameter int COORD_W    = 2,
  parameter int AGE_W      = 4,
  parameter int EJ_CREDITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [WIDTH-1:0]   flit_in,
  input  logic               valid_in,
  input  logic               hold,
  input  logic               ej_credit_ret,
  output logic [WIDTH-1:0]   flit_out,
  output logic               valid_out,
  output logic [2:0]         sel_out,
  output logic               deflect_out,
  output logic [2:0]         credits_out
);

  // Field positions inside the flit.
  localparam int DSTX_MSB = WIDTH - 1;
  localparam int DSTY_MSB = WIDTH - 1 - COORD_W;
  localparam int AGE_MSB  = WIDTH - 1 - 2 * COORD_W;

  localparam logic [AGE_W-1:0] AGE_MAX   = '1;
  localparam logic [2:0]       CRED_INIT = 3'(EJ_CREDITS);

  // Demux select encoding; the mesh directions double as round-robin slots.
  typedef enum logic [2:0] {
    SEL_NORTH = 3'b000,
    SEL_EAST  = 3'b001,
    SEL_SOUTH = 3'b010,
    SEL_WEST  = 3'b011,
    SEL_LOCAL = 3'b100
  } sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_flit;
  logic             r_valid;
  sel_e             r_sel;
  logic             r_deflect;
  logic [2:0]       r_credits;
  sel_e             r_rr_ptr;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming flit
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] w_dst_x;
  logic [COORD_W-1:0] w_dst_y;
  logic [AGE_W-1:0]   w_age;
  logic [AGE_W-1:0]   w_age_next;
  logic [WIDTH-1:0]   w_flit_next;
  sel_e               w_route;
  sel_e               w_rr_next;
  logic               w_capture;
  logic               w_to_local;
  logic               w_no_credit;
  logic               w_deflect;
  logic               w_consume;
  logic [2:0]         w_credits_next;

  assign w_dst_x = flit_in[DSTX_MSB -: COORD_W];
  assign w_dst_y = flit_in[DSTY_MSB -: COORD_W];
  assign w_age   = flit_in[AGE_MSB  -: AGE_W];

  // Age saturates so the oldest flits keep top priority instead of wrapping
  // back to look brand new.
  assign w_age_next = (w_age == AGE_MAX) ? w_age : w_age + 1'b1;

  always_comb begin
    w_flit_next                      = flit_in;
    w_flit_next[AGE_MSB -: AGE_W]    = w_age_next;
  end

  // XY routing: resolve X completely before moving in Y; unsigned compares.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_route = SEL_LOCAL;
    if (w_dst_x > cur_x) begin
      w_route = SEL_EAST;
    end else if (w_dst_x < cur_x) begin
      w_route = SEL_WEST;
    end else if (w_dst_y > cur_y) begin
      w_route = SEL_NORTH;
    end else if (w_dst_y < cur_y) begin
      w_route = SEL_SOUTH;
    end
  end

  // Round-robin order for deflections: N -> E -> S -> W -> N.
  always_comb begin
    w_rr_next = SEL_NORTH;
    case (r_rr_ptr)
      SEL_NORTH: w_rr_next = SEL_EAST;
      SEL_EAST:  w_rr_next = SEL_SOUTH;
      SEL_SOUTH: w_rr_next = SEL_WEST;
      default:   w_rr_next = SEL_NORTH;
    endcase
  end

  assign w_capture   = !hold && valid_in;
  assign w_to_local  = (w_route == SEL_LOCAL);
  // The credit decision looks only at the current count; a credit coming back
  // in the same cycle cannot rescue a flit that is already being deflected.
  assign w_no_credit = (r_credits == 3'd0);
  assign w_deflect   = w_capture && w_to_local &&  w_no_credit;
  assign w_consume   = w_capture && w_to_local && !w_no_credit;

  // Credit counter: a simultaneous consume and return cancel out; a return
  // with no consume saturates at the reset count.
  always_comb begin
    w_credits_next = r_credits;
    if (w_consume && !ej_credit_ret) begin
      w_credits_next = r_credits - 3'd1;
    end else if (ej_credit_ret && !w_consume && (r_credits < CRED_INIT)) begin
      w_credits_next = r_credits + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flit    <= '0;
      r_valid   <= 1'b0;
      r_sel     <= SEL_NORTH;
      r_deflect <= 1'b0;
      r_credits <= CRED_INIT;
      r_rr_ptr  <= SEL_NORTH;
    end else begin
      // Credit returns are counted even while the stage is stalled.
      r_credits <= w_credits_next;

      if (!hold) begin
        if (valid_in) begin
          r_flit  <= w_flit_next;
          r_valid <= 1'b1;
          if (w_deflect) begin
            r_sel     <= r_rr_ptr;
            r_deflect <= 1'b1;
            r_rr_ptr  <= w_rr_next;
          end else begin
            r_sel     <= w_route;
            r_deflect <= 1'b0;
          end
        end else begin
          // Idle: the data register keeps its last value, only the control
          // outputs drop so the demux sees a clean "nothing" select.
          r_valid   <= 1'b0;
          r_sel     <= SEL_NORTH;
          r_deflect <= 1'b0;
        end
      end
    end
  end

  assign flit_out    = r_flit;
  assign valid_out   = r_valid;
  assign sel_out     = r_sel;
  assign deflect_out = r_deflect;
  assign credits_out = r_credits;

endmodule

// File: tb/tb_bless_route_stage.sv
// -----------------------------------------------------------------------------
// tb_bless_route_stage
//
// Self-checking bench for bless_route_stage (default parameters, router at
// (1,1)). Each driven cycle pushes the expected registered outputs, produced
// by a small behavioural reference, into a scoreboard queue; one cycle later
// the entry is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_bless_route_stage;

  localparam int WIDTH      = 64;
  localparam int COORD_W    = 2;
  localparam int AGE_W      = 4;
  localparam int EJ_CREDITS = 2;

  logic               clk;
  logic               reset;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [WIDTH-1:0]   flit_in;
  logic               valid_in;
  logic               hold;
  logic               ej_credit_ret;
  logic [WIDTH-1:0]   flit_out;
  logic               valid_out;
  logic [2:0]         sel_out;
  logic               deflect_out;
  logic [2:0]         credits_out;

  bless_route_stage #(
    .WIDTH      (WIDTH),
    .COORD_W    (COORD_W),
    .AGE_W      (AGE_W),
    .EJ_CREDITS (EJ_CREDITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .flit_in       (flit_in),
    .valid_in      (valid_in),
    .hold          (hold),
    .ej_credit_ret (ej_credit_ret),
    .flit_out      (flit_out),
    .valid_out     (valid_out),
    .sel_out       (sel_out),
    .deflect_out   (deflect_out),
    .credits_out   (credits_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] flit;
    logic [2:0]       sel;
    logic             defl;
    logic [2:0]       cred;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  // Reference state: what the stage registers should hold.
  logic             m_valid;
  logic [WIDTH-1:0] m_flit;
  logic [2:0]       m_sel;
  logic             m_defl;
  int               m_cred;
  int               m_ptr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int dx, input int dy, input int age,
                                          input logic [55:0] pay);
    logic [WIDTH-1:0] f;
    f        = '0;
    f[63:62] = 2'(dx);
    f[61:60] = 2'(dy);
    f[59:56] = 4'(age);
    f[55:0]  = pay;
    return f;
  endfunction

  // Direction number per the select encoding: N=0 E=1 S=2 W=3 L=4.
  function automatic int route_of(input logic [WIDTH-1:0] f);
    int dx, dy, cx, cy;
    dx = int'(f[63:62]);
    dy = int'(f[61:60]);
    cx = int'(cur_x);
    cy = int'(cur_y);
    if (dx != cx) return (dx > cx) ? 1 : 3;
    if (dy != cy) return (dy > cy) ? 0 : 2;
    return 4;
  endfunction

  task automatic model(input logic rst, input logic hld, input logic vld,
                       input logic [WIDTH-1:0] f, input logic ret);
    int  r, a;
    logic used;
    if (rst) begin
      m_valid = 1'b0; m_flit = '0; m_sel = 3'd0; m_defl = 1'b0;
      m_cred  = EJ_CREDITS; m_ptr = 0;
      return;
    end
    used = 1'b0;
    if (!hld) begin
      if (vld) begin
        r = route_of(f);
        a = int'(f[59:56]);
        if (a < 15) a = a + 1;
        m_flit        = f;
        m_flit[59:56] = 4'(a);
        m_valid       = 1'b1;
        if (r == 4 && m_cred == 0) begin
          m_sel  = 3'(m_ptr);
          m_defl = 1'b1;
          m_ptr  = (m_ptr + 1) % 4;
        end else begin
          m_sel  = 3'(r);
          m_defl = 1'b0;
          used   = (r == 4);
        end
      end else begin
        m_valid = 1'b0; m_sel = 3'd0; m_defl = 1'b0;
      end
    end
    if (used && !ret)                              m_cred = m_cred - 1;
    else if (ret && !used && m_cred < EJ_CREDITS)  m_cred = m_cred + 1;
  endtask

  // One clock: drive, predict, wait for the edge, compare.
  task automatic step(input logic rst, input logic hld, input logic vld,
                      input logic [WIDTH-1:0] f, input logic ret);
    exp_t e;
    reset = rst; hold = hld; valid_in = vld; flit_in = f; ej_credit_ret = ret;
    model(rst, hld, vld, f, ret);
    e.valid = m_valid; e.flit = m_flit; e.sel = m_sel; e.defl = m_defl; e.cred = 3'(m_cred);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({phase, ".valid"},   64'(valid_out),   64'(e.valid));
    check({phase, ".flit"},    flit_out,          e.flit);
    check({phase, ".sel"},     64'(sel_out),     64'(e.sel));
    check({phase, ".deflect"}, 64'(deflect_out), 64'(e.defl));
    check({phase, ".credits"}, 64'(credits_out), 64'(e.cred));
  endtask

  task automatic send(input int dx, input int dy, input int age, input logic ret);
    step(1'b0, 1'b0, 1'b1, mk(dx, dy, age, 56'(64'h00A5_5A12_3456_789A) ^ 56'(dx * 7 + dy)), ret);
  endtask

  task automatic idle(input logic hld, input logic ret);
    step(1'b0, hld, 1'b0, '0, ret);
  endtask

  initial begin
    cur_x = 2'd1; cur_y = 2'd1;
    reset = 1'b1; hold = 1'b0; valid_in = 1'b0; flit_in = '0; ej_credit_ret = 1'b0;

    phase = "reset";
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Plain XY routing, fresh flits age 0 -> 1.
    phase = "route";
    send(3, 0, 0, 1'b0);   // East
    send(0, 3, 0, 1'b0);   // West
    send(1, 2, 0, 1'b0);   // North
    send(1, 0, 0, 1'b0);   // South
    send(3, 3, 7, 1'b0);   // X resolved first -> East

    // Local ejection consumes credits; age 15 saturates.
    phase = "local";
    send(1, 1, 15, 1'b0);
    send(1, 1, 3, 1'b0);

    // Out of credits: round-robin deflection N, E, S.
    phase = "deflect";
    send(1, 1, 0, 1'b0);
    send(1, 1, 0, 1'b0);
    send(1, 1, 0, 1'b0);

    // Same-cycle return does not prevent deflection (uses West, wraps to N).
    phase = "ret_same";
    send(1, 1, 0, 1'b1);
    send(1, 1, 0, 1'b0);   // credit available -> Local
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);      // saturates at EJ_CREDITS
    send(1, 1, 2, 1'b1);   // consume and return together -> unchanged

    // Stall with a captured flit; credit return still counted while held.
    phase = "hold";
    send(2, 1, 4, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    phase = "release";
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);      // flit_out keeps its value while idle

    // Drain credits and move pointer to South, then reset mid-stream.
    phase = "midreset";
    send(1, 1, 0, 1'b0);
    send(1, 1, 0, 1'b0);
    send(1, 1, 0, 1'b0);   // N
    send(1, 1, 0, 1'b0);   // E
    step(1'b1, 1'b0, 1'b1, mk(3, 0, 5, 56'h123), 1'b0);
    phase = "post_reset";
    send(1, 1, 0, 1'b0);
    send(1, 1, 0, 1'b0);
    send(1, 1, 0, 1'b0);   // deflected to North again

    // Random traffic with random holds and returns.
    phase = "random";
    for (int i = 0; i < 60; i++) begin
      logic h, v, r;
      h = ($urandom_range(0, 4) == 0);
      v = !h && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      step(1'b0, h, v,
           mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), 56'({$urandom, $urandom})), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bless_route_stage.md
Name: bless_route_stage

Overview:
- Pipeline stage directly upstream of the 1-to-5 output demux in the BLESS router.
- Registers one incoming flit and computes the 3-bit demux select by XY routing from the flit's destination field.
- Saturating-increments the flit age field on each hop.
- Tracks local-ejection credits. When the ejection port has no credit, a local-bound flit is deflected to a round-robin mesh direction.

Parameters:
- WIDTH, 64: flit width in bits; must be >= 2*COORD_W+AGE_W+1.
- COORD_W, 2: bits per mesh coordinate.
- AGE_W, 4: bits of the flit age field.
- EJ_CREDITS, 2: ejection-port credit count after reset; range 1..7.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cur_x  in  COORD_W  this router's X coordinate; static.
- cur_y  in  COORD_W  this router's Y coordinate; static.
- flit_in  in  WIDTH  incoming flit.
- valid_in  in  1  flit_in is valid this cycle.
- hold  in  1  stall; stage register and pointers keep their values.
- ej_credit_ret  in  1  one ejection credit returned this cycle.
- flit_out  out  WIDTH  registered flit, age updated; drives demux din.
- valid_out  out  1  flit_out valid.
- sel_out  out  3  demux select, registered with flit_out.
- deflect_out  out  1  registered flit was deflected from Local.
- credits_out  out  3  current ejection credit count.

Behaviour:
- Flit fields:
  - dst_x = flit[WIDTH-1 -: COORD_W].
  - dst_y = flit[WIDTH-1-COORD_W -: COORD_W].
  - age = flit[WIDTH-1-2*COORD_W -: AGE_W].
  - Remaining bits pass unchanged.
- sel encoding (fixed): 000 North, 001 East, 010 South, 011 West, 100 Local. Codes 101–111 are never produced.
- Route function (unsigned compares, X first):
  - dst_x>cur_x -> East; dst_x<cur_x -> West.
  - Otherwise dst_y>cur_y -> North; dst_y<cur_y -> South.
  - Otherwise Local.
- Reset values:
  - flit_out=0, valid_out=0, sel_out=000, deflect_out=0.
  - credits=EJ_CREDITS.
  - rr_ptr=North.
- Latency: exactly 1 cycle from valid_in (with hold=0) to valid_out.
- Capture (hold=0, valid_in=1):
  - flit_out <= flit_in with age replaced by min(age+1, 2^AGE_W-1).
  - valid_out <= 1.
  - sel_out <= route result, except when route=Local and credits==0.
  - Local with credits==0: sel_out <= rr_ptr, deflect_out <= 1, rr_ptr advances N->E->S->W->N.
  - Otherwise deflect_out <= 0.
- Idle (hold=0, valid_in=0):
  - valid_out <= 0, sel_out <= 000, deflect_out <= 0.
  - flit_out keeps its previous value.
  - No credit consumption, no pointer change.
- hold=1:
  - flit_out, valid_out, sel_out, deflect_out and rr_ptr all keep their values.
  - flit_in is dropped; upstream guarantees valid_in=0 while hold=1.
- Credit counter:
  - Decrements by 1 when a capture produces sel_out=Local (non-deflected).
  - Increments by 1 on ej_credit_ret.
  - Both in the same cycle: net unchanged.
  - A return while credits==EJ_CREDITS with no decrement is ignored (saturate).
  - Never underflows: the decrement occurs only when credits>0.
  - Returns are counted while hold=1.
- The credit decision uses the pre-update credit value. A credit returned in the same cycle does not prevent a deflection.
- credits_out is the counter value, registered.
- reset asserted mid-stream: all state returns to reset values on that edge. The in-flight flit is discarded and credits are restored to EJ_CREDITS.
- Age at saturation stays at 2^AGE_W-1; it never wraps to 0.

Test Plan:
- Reset, then cur=(1,1), 1 cycle each with valid_in=1 and ages 0: flit dst=(3,0) -> sel 001; dst=(0,3) -> sel 011; dst=(1,2) -> sel 000; dst=(1,0) -> sel 010. Each appears on the cycle after input with age 1.
- Flit dst=(1,1), age=15 -> sel 100, age stays 15, credits 2->1. A second local flit -> credits 0.
- With credits=0, three local flits back-to-back -> sel 000, 001, 010, each with deflect_out=1. rr_ptr is then West; credits stay 0.
- credits=0: ej_credit_ret=1 together with a local flit -> flit deflected, credits become 1. Next local flit -> sel 100, credits 0. With credits=2, an extra ej_credit_ret -> credits stay 2.
- Capture flit A (dst=(2,1)), then hold=1 for 3 cycles -> flit_out, sel 001 and valid_out=1 stay constant. Release with valid_in=0 -> valid_out=0, sel 000 next cycle.
- Mid-stream reset after credits reach 0 and rr_ptr=South -> next cycle valid_out=0, credits_out=2. The next deflection uses North.
